// File: rtl/cordic_phase_gen.sv
// -----------------------------------------------------------------------------
// cordic_phase_gen
//
// Phase-accumulator front end for a CORDIC sine/cosine generator. The unit
// accumulates a frequency control word and adds a phase offset. It then splits
// the full-circle phase into a quadrant (quad) and an angle within that
// quadrant (theta, Q1.16, 0..pi/2). The downstream rotator uses this
// sign/swap convention (s, c are the CORDIC outputs for theta):
//   q0 -> ( s,  c)   q1 -> ( c, -s)   q2 -> (-s, -c)   q3 -> (-c,  s)
//
// Pipeline:
//   stage 1 : p  = acc + phase_off (registered), v1 marks it valid,
//             acc advances by fcw on the same edge.
//   stage 2 : quad/theta derived from p, theta_valid follows v1.
//
// Handshake (theta_valid / theta_ready): a sample transfers on a rising edge
// where theta_valid and theta_ready are both high. While theta_valid is high
// and theta_ready is low, the pipeline is stalled. In that state theta, quad,
// theta_valid, stage 1 and acc all hold, and en is ignored. Nothing is dropped
// or repeated.
//
// sync_clr clears the accumulator and flushes both stages, even during a stall.
// It has priority over an advance in the same cycle.
//
// Optional feature: define CORDIC_PHASE_DITHER_EN to add a 16-bit Fibonacci
// LFSR (taps 16,14,13,11, seed 16'hACE1). The LFSR steps on every advance.
// Its low PHASE_W-18 bits are added to p below the theta resolution, so a
// carry can propagate into f and quad. The dither build assumes
// 19 <= PHASE_W <= 34.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   en           in   request to advance the phase by one sample
//   fcw          in   [PHASE_W-1:0] frequency control word (unsigned)
//   phase_off    in   [PHASE_W-1:0] phase offset (unsigned, modulo 2^PHASE_W)
//   sync_clr     in   synchronous accumulator clear + pipeline flush
//   theta_ready  in   downstream accepts theta/quad
//   theta_valid  out  theta/quad hold a valid sample
//   theta        out  [16:0] angle within quadrant, Q1.16 unsigned
//   quad         out  [1:0] quadrant of the full-circle phase
// -----------------------------------------------------------------------------
module cordic_phase_gen #(
  parameter int PHASE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] fcw,
  input  logic [PHASE_W-1:0] phase_off,
  input  logic               sync_clr,
  input  logic               theta_ready,
  output logic               theta_valid,
  output logic [16:0]        theta,
  output logic [1:0]         quad
);

  localparam logic [16:0] HALF_PI_Q16 = 17'h19220;

  logic [PHASE_W-1:0] acc;
  // Only the top 18 bits of p (2 quadrant bits + 16 fraction bits) are ever
  // consumed, so only those bits are stored.
  logic [17:0]        p_hi;
  logic               v1;
  logic               stall;
  logic               advance;
  logic [PHASE_W-1:0] phase_sum;
  logic [15:0]        f;
  logic [32:0]        prod;
  logic [16:0]        theta_next;

  assign stall   = theta_valid & ~theta_ready;
  assign advance = en & ~stall;

`ifdef CORDIC_PHASE_DITHER_EN
  localparam int DW = PHASE_W - 18;

  logic [15:0]        lfsr;
  logic               lfsr_fb;
  logic [PHASE_W-1:0] dither;

  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign dither    = {{(PHASE_W-DW){1'b0}}, lfsr[DW-1:0]};
  assign phase_sum = acc + phase_off + dither;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (advance && !sync_clr) begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end
`else
  assign phase_sum = acc + phase_off;
`endif

  // theta = f * (pi/2 in Q1.16) >> 16; max is 102942, below pi/2, so no clamp.
  assign f          = p_hi[15:0];
  assign prod       = {17'd0, f} * {16'd0, HALF_PI_Q16};
  assign theta_next = 17'(prod >> 16);

  // Stage 1: accumulator and registered phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      p_hi <= '0;
      v1   <= 1'b0;
    end else if (sync_clr) begin
      acc <= '0;
      v1  <= 1'b0;
    end else if (advance) begin
      p_hi <= 18'(phase_sum >> (PHASE_W - 18));
      v1   <= 1'b1;
      acc  <= acc + fcw;
    end else if (!stall) begin
      v1 <= 1'b0;
    end
  end

  // Stage 2: quadrant / angle outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      theta_valid <= 1'b0;
      theta       <= '0;
      quad        <= '0;
    end else if (sync_clr) begin
      theta_valid <= 1'b0;
    end else if (!stall) begin
      quad        <= p_hi[17:16];
      theta       <= theta_next;
      theta_valid <= v1;
    end
  end

endmodule

// File: tb/tb_cordic_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_cordic_phase_gen
//
// Directed bench for cordic_phase_gen (default build, dithering disabled).
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, so they show the result of the edge that just occurred.
// -----------------------------------------------------------------------------
module tb_cordic_phase_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] fcw;
  logic [31:0] phase_off;
  logic        sync_clr;
  logic        theta_ready;
  logic        theta_valid;
  logic [16:0] theta;
  logic [1:0]  quad;

  int checks   = 0;
  int failures = 0;

  cordic_phase_gen #(.PHASE_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .fcw         (fcw),
    .phase_off   (phase_off),
    .sync_clr    (sync_clr),
    .theta_ready (theta_ready),
    .theta_valid (theta_valid),
    .theta       (theta),
    .quad        (quad)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst         = 1'b1;
    en          = 1'b0;
    sync_clr    = 1'b0;
    theta_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Theta for phases k * 2^28 within a quadrant: 0, pi/8, pi/4, 3pi/8.
  logic [16:0] th16 [4];
  initial begin
    th16[0] = 17'h00000;
    th16[1] = 17'h06488;
    th16[2] = 17'h0C910;
    th16[3] = 17'h12D98;
  end

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (theta_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%0b exp=0", theta_valid);
    end
    checks++;
    if (theta !== 17'd0) begin
      failures++; $display("FAIL reset_theta got=%h exp=0", theta);
    end
    checks++;
    if (quad !== 2'd0) begin
      failures++; $display("FAIL reset_quad got=%0d exp=0", quad);
    end
    do_reset();
  endtask

  // Quarter-turn steps: quadrants 0,1,2,3,0 each with theta 0, one per cycle.
  task automatic test_quadrants;
    do_reset();
    fcw = 32'h4000_0000; phase_off = 32'h0; en = 1'b1; theta_ready = 1'b1;
    step();
    checks++;
    if (theta_valid !== 1'b0) begin
      failures++; $display("FAIL quad_latency got=%0b exp=0", theta_valid);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (theta_valid !== 1'b1 || quad !== 2'(k % 4) || theta !== 17'd0) begin
        failures++;
        $display("FAIL quad_seq[%0d] got v=%0b q=%0d t=%h exp v=1 q=%0d t=0",
                 k, theta_valid, quad, theta, k % 4);
      end
    end
    en = 1'b0;
  endtask

  // Eighth-turn steps: second sample is pi/4 in quadrant 0.
  task automatic test_eighth;
    logic [1:0]  eq [3];
    logic [16:0] et [3];
    eq[0] = 2'd0; et[0] = 17'h00000;
    eq[1] = 2'd0; et[1] = 17'h0C910;
    eq[2] = 2'd1; et[2] = 17'h00000;
    do_reset();
    fcw = 32'h2000_0000; phase_off = 32'h0; en = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (theta_valid !== 1'b1 || quad !== eq[k] || theta !== et[k]) begin
        failures++;
        $display("FAIL eighth[%0d] got v=%0b q=%0d t=%h exp v=1 q=%0d t=%h",
                 k, theta_valid, quad, theta, eq[k], et[k]);
      end
    end
    en = 1'b0;
  endtask

  // Back-pressure for 5 cycles mid-stream; expected queue of sample indices.
  task automatic test_stall;
    int n;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    do_reset();
    fcw = 32'h1000_0000; phase_off = 32'h0; en = 1'b1;
    for (int i = 0; i < 32; i++) exp_q.push_back(i);
    n = 0;
    for (int c = 0; c < 25; c++) begin
      theta_ready = !(c >= 8 && c < 13);
      checks++;
      if (theta_valid !== (c >= 2)) begin
        failures++;
        $display("FAIL stall_valid[%0d] got=%0b exp=%0b", c, theta_valid, c >= 2);
      end
      if (theta_valid === 1'b1) begin
        e = exp_q[0];
        checks++;
        if (quad !== 2'((e >> 2) & 3) || theta !== th16[e % 4]) begin
          failures++;
          $display("FAIL stall_data[%0d] got q=%0d t=%h exp q=%0d t=%h",
                   c, quad, theta, (e >> 2) & 3, th16[e % 4]);
        end
        if (theta_ready) begin
          void'(exp_q.pop_front());
          n++;
        end
      end
      step();
    end
    checks++;
    if (n != 18) begin
      failures++; $display("FAIL stall_count got=%0d exp=18", n);
    end
    en = 1'b0; theta_ready = 1'b1;
  endtask

  // sync_clr with en: flush, then restart from phase_off.
  task automatic test_sync_clr;
    do_reset();
    fcw = 32'h1000_0000; phase_off = 32'h5000_0000; en = 1'b1;
    repeat (4) step();
    checks++;
    if (theta_valid !== 1'b1) begin
      failures++; $display("FAIL clr_pre_valid got=%0b exp=1", theta_valid);
    end
    sync_clr = 1'b1;
    step();
    checks++;
    if (theta_valid !== 1'b0) begin
      failures++; $display("FAIL clr_flush got=%0b exp=0", theta_valid);
    end
    sync_clr = 1'b0;
    step();
    checks++;
    if (theta_valid !== 1'b0) begin
      failures++; $display("FAIL clr_gap got=%0b exp=0", theta_valid);
    end
    step();
    checks++;
    if (theta_valid !== 1'b1 || quad !== 2'd1 || theta !== 17'h06488) begin
      failures++;
      $display("FAIL clr_first got v=%0b q=%0d t=%h exp v=1 q=1 t=06488",
               theta_valid, quad, theta);
    end
    step();
    checks++;
    if (theta_valid !== 1'b1 || quad !== 2'd1 || theta !== 17'h0C910) begin
      failures++;
      $display("FAIL clr_second got v=%0b q=%0d t=%h exp v=1 q=1 t=0C910",
               theta_valid, quad, theta);
    end
    en = 1'b0;
  endtask

  // Asynchronous reset pulse between edges, then restart sequence.
  task automatic test_async_reset;
    do_reset();
    fcw = 32'h4000_0000; phase_off = 32'h0; en = 1'b1;
    repeat (4) step();
    checks++;
    if (theta_valid !== 1'b1 || quad !== 2'd2) begin
      failures++;
      $display("FAIL arst_pre got v=%0b q=%0d exp v=1 q=2", theta_valid, quad);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (theta_valid !== 1'b0 || quad !== 2'd0 || theta !== 17'd0) begin
      failures++;
      $display("FAIL arst_now got v=%0b q=%0d t=%h exp v=0 q=0 t=0",
               theta_valid, quad, theta);
    end
    #2 rst = 1'b0;
    step();
    checks++;
    if (theta_valid !== 1'b0) begin
      failures++; $display("FAIL arst_latency got=%0b exp=0", theta_valid);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (theta_valid !== 1'b1 || quad !== 2'(k % 4) || theta !== 17'd0) begin
        failures++;
        $display("FAIL arst_seq[%0d] got v=%0b q=%0d t=%h exp v=1 q=%0d t=0",
                 k, theta_valid, quad, theta, k % 4);
      end
    end
    en = 1'b0;
  endtask

  // Top-of-circle wrap: max theta in quadrant 3, then back to 0.
  task automatic test_wrap;
    do_reset();
    fcw = 32'h0000_0001; phase_off = 32'hFFFF_FFFF; en = 1'b1;
    step();
    step();
    checks++;
    if (theta_valid !== 1'b1 || quad !== 2'd3 || theta !== 17'd102942) begin
      failures++;
      $display("FAIL wrap_first got v=%0b q=%0d t=%0d exp v=1 q=3 t=102942",
               theta_valid, quad, theta);
    end
    step();
    checks++;
    if (theta_valid !== 1'b1 || quad !== 2'd0 || theta !== 17'd0) begin
      failures++;
      $display("FAIL wrap_second got v=%0b q=%0d t=%0d exp v=1 q=0 t=0",
               theta_valid, quad, theta);
    end
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; sync_clr = 1'b0; theta_ready = 1'b1;
    fcw = '0; phase_off = '0;
    test_reset();
    test_quadrants();
    test_eighth();
    test_stall();
    test_sync_clr();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
